mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Multi-cycle memory responder for a CPU's instruction and data ports.
// A fetch is served first, then the data access; stall is held while either is in service.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] icache_addr,
    input  logic        icache_re,
    output logic [31:0] icache_dout,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic [31:0] stall_count
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0]  RELOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, DONE} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   i_index;
    logic [ADDR_WIDTH-1:0]   d_index;
    logic [31:0]             din_q;
    logic [3:0]              we_q;
    logic                    i_re_q;
    logic                    d_re_q;
    logic                    d_wr_q;
    logic [31:0]             mem [DEPTH];

    logic accept;
    logic d_fire;
    logic unused_addr_bits;

    assign stall  = (state == I_WAIT) || (state == D_WAIT);
    assign accept = ((state == IDLE) || (state == DONE)) &&
                    (icache_re || dcache_re || (dcache_we != 4'h0));
    assign d_fire = (state == D_WAIT) && (cnt == 4'h0);

    // Byte offset and bits above the array alias onto the same word.
    assign unused_addr_bits = ^{icache_addr[31:ADDR_WIDTH+2], icache_addr[1:0],
                                dcache_addr[31:ADDR_WIDTH+2], dcache_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'h0;
            icache_dout <= 32'h0;
            dcache_dout <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (stall) stall_count <= stall_count + 32'd1;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        i_index <= icache_addr[ADDR_WIDTH+1:2];
                        d_index <= dcache_addr[ADDR_WIDTH+1:2];
                        din_q   <= dcache_din;
                        we_q    <= dcache_we;
                        i_re_q  <= icache_re;
                        d_re_q  <= dcache_re;
                        d_wr_q  <= (dcache_we != 4'h0);
                        cnt     <= RELOAD;
                        state   <= icache_re ? I_WAIT : D_WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                I_WAIT: begin
                    if (cnt == 4'h0) begin
                        if (i_re_q) icache_dout <= mem[i_index];
                        if (d_re_q || d_wr_q) begin
                            cnt   <= RELOAD;
                            state <= D_WAIT;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                D_WAIT: begin
                    if (cnt == 4'h0) begin
                        if (d_re_q) dcache_dout <= mem[d_index];
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a reset edge suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!reset && d_fire) begin
            for (int n = 0; n < 4; n++) begin
                if (we_q[n]) mem[d_index][8*n +: 8] <= din_q[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed test of mem_responder with LATENCY=2: stall timing, byte lanes, ordering, reset.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;
    int n;

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .icache_addr(icache_addr),
        .icache_re  (icache_re),
        .icache_dout(icache_dout),
        .dcache_addr(dcache_addr),
        .dcache_re  (dcache_re),
        .dcache_we  (dcache_we),
        .dcache_din (dcache_din),
        .dcache_dout(dcache_dout),
        .stall      (stall),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        icache_addr = 32'h0;
        icache_re   = 1'b0;
        dcache_addr = 32'h0;
        dcache_re   = 1'b0;
        dcache_we   = 4'h0;
        dcache_din  = 32'h0;
    endtask

    task automatic drive(input logic [31:0] ia, input logic ire, input logic [31:0] da,
                         input logic dre, input logic [3:0] we, input logic [31:0] din);
        icache_addr = ia;
        icache_re   = ire;
        dcache_addr = da;
        dcache_re   = dre;
        dcache_we   = we;
        dcache_din  = din;
    endtask

    // Entered at a negedge; returns at the first negedge with stall low.
    task automatic req(input logic [31:0] ia, input logic ire, input logic [31:0] da,
                       input logic dre, input logic [3:0] we, input logic [31:0] din,
                       input bit hold, output int cycles);
        drive(ia, ire, da, dre, we, din);
        @(negedge clk);
        if (!hold) clear_inputs();
        cycles = 0;
        while (stall === 1'b1 && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_idout", icache_dout, 32'h0);
        check("rst_ddout", dcache_dout, 32'h0);
        check("rst_count", stall_count, 32'h0);
        reset = 1'b0;

        req(32'h0, 1'b0, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0, n);
        check("store_cycles", 32'(n), 32'd2);
        check("store_stall_low", 32'(stall), 32'd0);

        req(32'h0, 1'b0, 32'h40, 1'b1, 4'h0, 32'h0, 1'b0, n);
        check("load_cycles", 32'(n), 32'd2);
        check("load_data", dcache_dout, 32'hDEADBEEF);
        check("load_count", stall_count, 32'd4);

        req(32'h0, 1'b0, 32'h42, 1'b0, 4'b0010, 32'h0000AB00, 1'b0, n);
        check("lane_store_cycles", 32'(n), 32'd2);
        req(32'h0, 1'b0, 32'h40, 1'b1, 4'h0, 32'h0, 1'b0, n);
        check("lane_load_data", dcache_dout, 32'hDEADABEF);
        check("lane_count", stall_count, 32'd8);

        req(32'h0, 1'b0, 32'h44, 1'b0, 4'hF, 32'h12345678, 1'b0, n);
        req(32'h40, 1'b1, 32'h44, 1'b1, 4'h0, 32'h0, 1'b0, n);
        check("fetch_load_cycles", 32'(n), 32'd4);
        check("fetch_data", icache_dout, 32'hDEADABEF);
        check("fetch_load_data", dcache_dout, 32'h12345678);
        check("fetch_load_count", stall_count, 32'd14);

        // Fetch and store to the same word: fetch sees old contents, dcache_dout holds.
        req(32'h44, 1'b1, 32'h44, 1'b0, 4'hF, 32'hAAAA5555, 1'b0, n);
        check("fetch_store_cycles", 32'(n), 32'd4);
        check("fetch_pre_write", icache_dout, 32'h12345678);
        check("ddout_hold", dcache_dout, 32'h12345678);

        // Inputs held through the stall must be ignored until DONE.
        req(32'h0, 1'b0, 32'h44, 1'b1, 4'h0, 32'h0, 1'b1, n);
        check("held_req_cycles", 32'(n), 32'd2);
        check("post_store_load", dcache_dout, 32'hAAAA5555);
        check("held_count", stall_count, 32'd20);
        check("idout_hold", icache_dout, 32'h12345678);

        req(32'h0, 1'b0, 32'h4047, 1'b1, 4'h0, 32'h0, 1'b0, n);
        check("alias_load", dcache_dout, 32'hAAAA5555);
        check("alias_count", stall_count, 32'd22);

        // Reset in the first D_WAIT cycle of a store.
        drive(32'h0, 1'b0, 32'h40, 1'b0, 4'hF, 32'hFFFFFFFF);
        @(negedge clk);
        clear_inputs();
        check("mid_store_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_count", stall_count, 32'd0);
        check("mid_rst_ddout", dcache_dout, 32'h0);
        reset = 1'b0;
        req(32'h0, 1'b0, 32'h40, 1'b1, 4'h0, 32'h0, 1'b0, n);
        check("mid_rst_mem", dcache_dout, 32'hDEADABEF);
        check("mid_rst_new_count", stall_count, 32'd2);

        // Reset on the very edge that would commit a store.
        drive(32'h0, 1'b0, 32'h44, 1'b0, 4'hF, 32'hFFFFFFFF);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("late_store_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("late_rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        req(32'h0, 1'b0, 32'h44, 1'b1, 4'h0, 32'h0, 1'b0, n);
        check("late_rst_mem", dcache_dout, 32'hAAAA5555);
        check("late_rst_count", stall_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
